// File: rtl/mio_bridge16.sv
// mio_bridge16: CPU MIO port to 16-bit synchronous block RAM and memory-mapped I/O.
// One request at a time. A word access takes two RAM cycles, a halfword access
// takes one, and an I/O access produces a single-cycle strobe. Completion is a
// one-cycle MIO_ready pulse. All outputs are registered.
module mio_bridge16 #(
  parameter int unsigned ADDR_W = 13,
  parameter logic [3:0]  IO_NIB = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic              Half_W,
  input  logic [31:0]       Addr_out,
  input  logic [31:0]       data_out,
  output logic [31:0]       data_in,
  output logic              MIO_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout,
  output logic              io_rd,
  output logic              io_wr,
  output logic [7:0]        io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_CAP,
    S_IOA,
    S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  // Latched request: only the fields needed after the accept edge are kept.
  logic [ADDR_W-2:0] r_addr_hi;
  logic [15:0]       r_wdata_hi;
  logic              r_w;
  logic              r_half;

  // Output registers.
  logic [31:0]       r_data_in;
  logic              r_ready;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [15:0]       r_ram_din;
  logic              r_io_rd;
  logic              r_io_wr;
  logic [7:0]        r_io_addr;
  logic [31:0]       r_io_wdata;

  // Next values of the output registers.
  logic [31:0]       w_data_in_nxt;
  logic              w_ready_nxt;
  logic              w_ram_en_nxt;
  logic              w_ram_we_nxt;
  logic [ADDR_W-1:0] w_ram_addr_nxt;
  logic [15:0]       w_ram_din_nxt;
  logic              w_io_rd_nxt;
  logic              w_io_wr_nxt;
  logic [7:0]        w_io_addr_nxt;
  logic [31:0]       w_io_wdata_nxt;

  logic w_is_io;
  logic w_accept;
  logic w_unused;

  assign w_is_io  = (Addr_out[31:28] == IO_NIB);
  assign w_accept = (r_state == S_IDLE) && CPU_MIO;
  // Address bits above the RAM size and bit 0 are deliberately ignored.
  assign w_unused = ^Addr_out;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request capture on the accept edge; held for the rest of the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_hi  <= '0;
      r_wdata_hi <= '0;
      r_w        <= 1'b0;
      r_half     <= 1'b0;
    end else if (w_accept) begin
      r_addr_hi  <= Addr_out[ADDR_W:2];
      r_wdata_hi <= data_out[31:16];
      r_w        <= mem_w;
      r_half     <= Half_W;
    end
  end

  // Next state and next output values; outputs follow the state being entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_data_in_nxt  = r_data_in;
    w_ready_nxt    = 1'b0;
    w_ram_en_nxt   = 1'b0;
    w_ram_we_nxt   = 1'b0;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_din_nxt  = r_ram_din;
    w_io_rd_nxt    = 1'b0;
    w_io_wr_nxt    = 1'b0;
    w_io_addr_nxt  = r_io_addr;
    w_io_wdata_nxt = r_io_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (CPU_MIO) begin
          if (w_is_io) begin
            w_state_nxt    = S_IOA;
            w_io_rd_nxt    = !mem_w;
            w_io_wr_nxt    = mem_w;
            w_io_addr_nxt  = Addr_out[9:2];
            w_io_wdata_nxt = data_out;
          end else begin
            w_state_nxt    = S_LO;
            w_ram_en_nxt   = 1'b1;
            w_ram_we_nxt   = mem_w;
            w_ram_addr_nxt = Half_W ? Addr_out[ADDR_W:1] : {Addr_out[ADDR_W:2], 1'b0};
            w_ram_din_nxt  = data_out[15:0];
          end
        end
      end
      S_LO: begin
        if (!r_half) begin
          w_state_nxt    = S_HI;
          w_ram_en_nxt   = 1'b1;
          w_ram_we_nxt   = r_w;
          w_ram_addr_nxt = {r_addr_hi, 1'b1};
          w_ram_din_nxt  = r_wdata_hi;
        end else if (r_w) begin
          w_state_nxt = S_DONE;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = S_CAP;
        end
      end
      S_HI: begin
        if (r_w) begin
          w_state_nxt = S_DONE;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt          = S_CAP;
          w_data_in_nxt[15:0]  = ram_dout;
        end
      end
      S_CAP: begin
        w_state_nxt = S_DONE;
        w_ready_nxt = 1'b1;
        if (r_half) w_data_in_nxt = {16'h0000, ram_dout};
        else        w_data_in_nxt[31:16] = ram_dout;
      end
      S_IOA: begin
        w_state_nxt = S_DONE;
        w_ready_nxt = 1'b1;
        if (!r_w) w_data_in_nxt = io_rdata;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_in  <= '0;
      r_ready    <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_io_rd    <= 1'b0;
      r_io_wr    <= 1'b0;
      r_io_addr  <= '0;
      r_io_wdata <= '0;
    end else begin
      r_data_in  <= w_data_in_nxt;
      r_ready    <= w_ready_nxt;
      r_ram_en   <= w_ram_en_nxt;
      r_ram_we   <= w_ram_we_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_ram_din  <= w_ram_din_nxt;
      r_io_rd    <= w_io_rd_nxt;
      r_io_wr    <= w_io_wr_nxt;
      r_io_addr  <= w_io_addr_nxt;
      r_io_wdata <= w_io_wdata_nxt;
    end
  end

  assign data_in   = r_data_in;
  assign MIO_ready = r_ready;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign io_rd     = r_io_rd;
  assign io_wr     = r_io_wr;
  assign io_addr   = r_io_addr;
  assign io_wdata  = r_io_wdata;

endmodule
